// File: rtl/sdram_arbiter.sv
// Slot-based SDRAM arbiter: each 2-cycle slot of F14M belongs to the download
// buffer, the video fetcher, the CPU, or nobody, and is decided at the slot boundary.
module sdram_arbiter #(
   parameter int ADDR_W     = 25,
   parameter int STARVE_MAX = 4
) (
   input  logic              F14M,
   input  logic              RESET,

   input  logic              dl_active,
   input  logic              dl_wr,
   input  logic [ADDR_W-1:0] dl_addr,
   input  logic [7:0]        dl_data,

   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic [7:0]        vid_data,
   output logic              vid_valid,

   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_din,
   output logic              cpu_ack,
   output logic [7:0]        cpu_dout,
   output logic              cpu_valid,
   output logic              cpu_wait_n,

   output logic              dl_overflow,

   output logic [ADDR_W-1:0] sd_addr,
   output logic [7:0]        sd_din,
   output logic              sd_we,
   output logic              sd_oe,
   input  logic [7:0]        sd_dout
);

   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   localparam logic [2:0] OWN_IDLE     = 3'd0;
   localparam logic [2:0] OWN_DL       = 3'd1;
   localparam logic [2:0] OWN_VID_RD   = 3'd2;
   localparam logic [2:0] OWN_VID_NULL = 3'd3;
   localparam logic [2:0] OWN_CPU_RD   = 3'd4;
   localparam logic [2:0] OWN_CPU_WR   = 3'd5;

   logic              phase_q,    phase_d;
   logic [2:0]        own_q,      own_d;
   logic [SW-1:0]     starve_q,   starve_d;
   logic              buf_full_q, buf_full_d;
   logic              overflow_q, overflow_d;
   logic              vid_ack_q,  vid_ack_d;
   logic              cpu_ack_q,  cpu_ack_d;
   logic              vid_valid_q, vid_valid_d;
   logic              cpu_valid_q, cpu_valid_d;
   logic [7:0]        vid_data_q, vid_data_d;
   logic [7:0]        cpu_dout_q, cpu_dout_d;
   logic [ADDR_W-1:0] sd_addr_q,  sd_addr_d;
   logic [7:0]        sd_din_q,   sd_din_d;
   logic              sd_we_q,    sd_we_d;
   logic              sd_oe_q,    sd_oe_d;
   logic [ADDR_W-1:0] buf_addr_q;
   logic [7:0]        buf_data_q;

   logic slot_end;
   logic freeing;
   logic buf_ready;
   logic cpu_ok;
   logic buf_load;
   logic grant_cpu;

   // The edge closing phase 1 both ends the running slot and starts the next one.
   assign slot_end  = phase_q;
   assign freeing   = slot_end && (own_q == OWN_DL);
   // An entry written on this very edge is not yet in buf_full_q, so it waits a slot.
   assign buf_ready = buf_full_q && !freeing;
   assign cpu_ok    = cpu_req && !dl_active;
   assign buf_load  = dl_wr && !(buf_full_q && !freeing);

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      phase_d     = ~phase_q;
      own_d       = own_q;
      starve_d    = starve_q;
      buf_full_d  = buf_full_q;
      overflow_d  = overflow_q;
      vid_ack_d   = 1'b0;
      cpu_ack_d   = 1'b0;
      vid_valid_d = 1'b0;
      cpu_valid_d = 1'b0;
      vid_data_d  = vid_data_q;
      cpu_dout_d  = cpu_dout_q;
      sd_addr_d   = sd_addr_q;
      sd_din_d    = sd_din_q;
      sd_we_d     = sd_we_q;
      sd_oe_d     = sd_oe_q;
      grant_cpu   = 1'b0;

      if (slot_end) begin
         case (own_q)
            OWN_VID_RD: begin
               vid_data_d  = sd_dout;
               vid_valid_d = 1'b1;
            end
            OWN_VID_NULL: begin
               vid_data_d  = 8'h00;
               vid_valid_d = 1'b1;
            end
            OWN_CPU_RD: begin
               cpu_dout_d  = sd_dout;
               cpu_valid_d = 1'b1;
            end
            default: ;
         endcase

         own_d   = OWN_IDLE;
         sd_we_d = 1'b0;
         sd_oe_d = 1'b0;

         if (buf_ready) begin
            own_d     = OWN_DL;
            sd_addr_d = buf_addr_q;
            sd_din_d  = buf_data_q;
            sd_we_d   = 1'b1;
         end else if (cpu_ok && (starve_q == STARVE_LIM)) begin
            grant_cpu = 1'b1;
         end else if (vid_req) begin
            vid_ack_d = 1'b1;
            if (dl_active) begin
               own_d = OWN_VID_NULL;
            end else begin
               own_d     = OWN_VID_RD;
               sd_addr_d = vid_addr;
               sd_oe_d   = 1'b1;
            end
            if (cpu_req && (starve_q != STARVE_LIM)) begin
               starve_d = starve_q + SW'(1);
            end
         end else if (cpu_ok) begin
            grant_cpu = 1'b1;
         end

         if (grant_cpu) begin
            cpu_ack_d = 1'b1;
            starve_d  = '0;
            sd_addr_d = cpu_addr;
            if (cpu_we) begin
               own_d    = OWN_CPU_WR;
               sd_din_d = cpu_din;
               sd_we_d  = 1'b1;
            end else begin
               own_d   = OWN_CPU_RD;
               sd_oe_d = 1'b1;
            end
         end
      end

      if (!cpu_req) begin
         starve_d = '0;
      end

      if (freeing) begin
         buf_full_d = 1'b0;
      end
      if (dl_wr) begin
         if (buf_load) begin
            buf_full_d = 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge F14M) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (!RESET) begin
         phase_q     <= 1'b0;
         own_q       <= OWN_IDLE;
         starve_q    <= '0;
         buf_full_q  <= 1'b0;
         overflow_q  <= 1'b0;
         vid_ack_q   <= 1'b0;
         cpu_ack_q   <= 1'b0;
         vid_valid_q <= 1'b0;
         cpu_valid_q <= 1'b0;
         vid_data_q  <= 8'h00;
         cpu_dout_q  <= 8'h00;
         sd_addr_q   <= '0;
         sd_din_q    <= 8'h00;
         sd_we_q     <= 1'b0;
         sd_oe_q     <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         own_q       <= own_d;
         starve_q    <= starve_d;
         buf_full_q  <= buf_full_d;
         overflow_q  <= overflow_d;
         vid_ack_q   <= vid_ack_d;
         cpu_ack_q   <= cpu_ack_d;
         vid_valid_q <= vid_valid_d;
         cpu_valid_q <= cpu_valid_d;
         vid_data_q  <= vid_data_d;
         cpu_dout_q  <= cpu_dout_d;
         sd_addr_q   <= sd_addr_d;
         sd_din_q    <= sd_din_d;
         sd_we_q     <= sd_we_d;
         sd_oe_q     <= sd_oe_d;
      end
   end

   // NOTE: buffer payload has no reset; it is only ever read while buf_full_q marks it valid.
   always_ff @(posedge F14M) begin
      if (buf_load) begin
         buf_addr_q <= dl_addr;
         buf_data_q <= dl_data;
      end
   end

   assign vid_ack     = vid_ack_q;
   assign vid_data    = vid_data_q;
   assign vid_valid   = vid_valid_q;
   assign cpu_ack     = cpu_ack_q;
   assign cpu_dout    = cpu_dout_q;
   assign cpu_valid   = cpu_valid_q;
   assign dl_overflow = overflow_q;
   assign sd_addr     = sd_addr_q;
   assign sd_din      = sd_din_q;
   assign sd_we       = sd_we_q;
   assign sd_oe       = sd_oe_q;

   // The Z80 is held off during downloads and while its request is still unserved.
   assign cpu_wait_n = !RESET || !(dl_active || (cpu_req && !cpu_ack_q));

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus randomized traffic,
// all compared every cycle against a slot-level reference model.
module tb_sdram_arbiter;

   localparam int AW   = 25;
   localparam int SMAX = 4;

   logic          F14M = 1'b0;
   logic          RESET;
   logic          dl_active, dl_wr;
   logic [AW-1:0] dl_addr;
   logic [7:0]    dl_data;
   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic          vid_ack, vid_valid;
   logic [7:0]    vid_data;
   logic          cpu_req, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_din;
   logic          cpu_ack, cpu_valid, cpu_wait_n, dl_overflow;
   logic [7:0]    cpu_dout;
   logic [AW-1:0] sd_addr;
   logic [7:0]    sd_din, sd_dout;
   logic          sd_we, sd_oe;

   always #5 F14M = ~F14M;

   sdram_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
      .F14M(F14M), .RESET(RESET),
      .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
      .vid_valid(vid_valid),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_ack(cpu_ack), .cpu_dout(cpu_dout), .cpu_valid(cpu_valid), .cpu_wait_n(cpu_wait_n),
      .dl_overflow(dl_overflow),
      .sd_addr(sd_addr), .sd_din(sd_din), .sd_we(sd_we), .sd_oe(sd_oe), .sd_dout(sd_dout)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model (one slot-level transaction at a time) -------------
   typedef enum {K_NONE, K_DL, K_VRD, K_VNULL, K_CRD, K_CWR} kind_e;

   kind_e         m_kind;
   bit            m_phase;
   bit            m_buf_v;
   logic [AW-1:0] m_buf_a;
   logic [7:0]    m_buf_d;
   int            m_streak;

   bit            e_vid_ack, e_cpu_ack, e_vid_valid, e_cpu_valid, e_sd_we, e_sd_oe, e_ovf;
   logic [7:0]    e_vid_data, e_cpu_dout, e_sd_din;
   logic [AW-1:0] e_sd_addr;

   bit            dout_fix_en = 1'b0;
   logic [7:0]    dout_fix = 8'h00;

   function automatic void model_step();
      kind_e pick;
      bit    closing, freeing, cpu_ok;
      if (!RESET) begin
         m_phase = 1'b0; m_kind = K_NONE; m_buf_v = 1'b0; m_streak = 0;
         e_vid_ack = 0; e_cpu_ack = 0; e_vid_valid = 0; e_cpu_valid = 0;
         e_vid_data = 8'h00; e_cpu_dout = 8'h00; e_sd_addr = '0; e_sd_din = 8'h00;
         e_sd_we = 0; e_sd_oe = 0; e_ovf = 0;
         return;
      end
      closing = m_phase;
      freeing = closing && (m_kind == K_DL);
      e_vid_ack = 0; e_cpu_ack = 0; e_vid_valid = 0; e_cpu_valid = 0;
      if (closing) begin
         if (m_kind == K_VRD)   begin e_vid_data = sd_dout; e_vid_valid = 1; end
         if (m_kind == K_VNULL) begin e_vid_data = 8'h00;   e_vid_valid = 1; end
         if (m_kind == K_CRD)   begin e_cpu_dout = sd_dout; e_cpu_valid = 1; end
         cpu_ok = cpu_req && !dl_active;
         if (m_buf_v && !freeing)             pick = K_DL;
         else if (cpu_ok && m_streak >= SMAX) pick = cpu_we ? K_CWR : K_CRD;
         else if (vid_req)                    pick = dl_active ? K_VNULL : K_VRD;
         else if (cpu_ok)                     pick = cpu_we ? K_CWR : K_CRD;
         else                                 pick = K_NONE;
         e_sd_we   = (pick == K_DL) || (pick == K_CWR);
         e_sd_oe   = (pick == K_VRD) || (pick == K_CRD);
         e_vid_ack = (pick == K_VRD) || (pick == K_VNULL);
         e_cpu_ack = (pick == K_CRD) || (pick == K_CWR);
         case (pick)
            K_DL:    begin e_sd_addr = m_buf_a;  e_sd_din = m_buf_d; end
            K_VRD:         e_sd_addr = vid_addr;
            K_CRD:         e_sd_addr = cpu_addr;
            K_CWR:   begin e_sd_addr = cpu_addr; e_sd_din = cpu_din; end
            default: ;
         endcase
         if (e_cpu_ack) m_streak = 0;
         else if (e_vid_ack && cpu_req) m_streak = (m_streak < SMAX) ? m_streak + 1 : SMAX;
         m_kind = pick;
      end
      if (!cpu_req) m_streak = 0;
      if (freeing) m_buf_v = 1'b0;
      if (dl_wr) begin
         if (m_buf_v) e_ovf = 1'b1;
         else begin m_buf_v = 1'b1; m_buf_a = dl_addr; m_buf_d = dl_data; end
      end
      m_phase = !m_phase;
   endfunction

   task automatic compare_all();
      logic exp_wait;
      exp_wait = !RESET || !(dl_active || (cpu_req && !e_cpu_ack));
      check("vid_ack",     vid_ack,     e_vid_ack);
      check("cpu_ack",     cpu_ack,     e_cpu_ack);
      check("vid_valid",   vid_valid,   e_vid_valid);
      check("cpu_valid",   cpu_valid,   e_cpu_valid);
      check("vid_data",    vid_data,    e_vid_data);
      check("cpu_dout",    cpu_dout,    e_cpu_dout);
      check("sd_we",       sd_we,       e_sd_we);
      check("sd_oe",       sd_oe,       e_sd_oe);
      check("sd_addr",     sd_addr,     e_sd_addr);
      check("sd_din",      sd_din,      e_sd_din);
      check("dl_overflow", dl_overflow, e_ovf);
      check("cpu_wait_n",  cpu_wait_n,  exp_wait);
   endtask

   // Inputs are driven at the falling edge; the model advances over the coming rising edge.
   task automatic tick();
      sd_dout = dout_fix_en ? dout_fix : 8'($urandom);
      model_step();
      @(posedge F14M);
      @(negedge F14M);
      compare_all();
   endtask

   task automatic do_reset();
      RESET = 1'b0;
      dl_active = 0; dl_wr = 0; dl_addr = '0; dl_data = 8'h00;
      vid_req = 0; vid_addr = '0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = 8'h00;
      dout_fix_en = 1'b0;
      tick();
      tick();
      RESET = 1'b1;
   endtask

   task automatic wait_cpu_ack(input int budget, output int n);
      n = 0;
      while (!cpu_ack && n < budget) begin
         tick();
         n++;
      end
   endtask

   // Download write monitor
   logic [AW-1:0] q_a[$];
   logic [7:0]    q_d[$];
   logic          prev_we;
   int            n_wr;
   int            n_wait_hi;

   task automatic tick_dl();
      tick();
      if (sd_we && !prev_we) begin
         n_wr++;
         check("dl_wr_expected", q_a.size() != 0, 1);
         if (q_a.size() != 0) begin
            check("dl_wr_addr", sd_addr, q_a.pop_front());
            check("dl_wr_data", sd_din,  q_d.pop_front());
         end
      end
      if (cpu_wait_n) n_wait_hi++;
      prev_we = sd_we;
   endtask

   task automatic rand_agents();
      RESET   = ($urandom_range(0, 299) != 0);
      dl_wr   = ($urandom_range(0, 5) == 0);
      dl_addr = AW'($urandom);
      dl_data = 8'($urandom);
      if ($urandom_range(0, 39) == 0) dl_active = ~dl_active;
      if (vid_ack) begin
         vid_req  = ($urandom_range(0, 2) == 0);
         vid_addr = AW'($urandom);
      end else if (!vid_req) begin
         if ($urandom_range(0, 2) == 0) begin vid_req = 1; vid_addr = AW'($urandom); end
      end else if ($urandom_range(0, 49) == 0) begin
         vid_req = 0;
      end
      if (cpu_ack) begin
         cpu_req  = ($urandom_range(0, 2) == 0);
         cpu_we   = $urandom_range(0, 1) == 1;
         cpu_addr = AW'($urandom);
         cpu_din  = 8'($urandom);
      end else if (!cpu_req) begin
         if ($urandom_range(0, 2) == 0) begin
            cpu_req = 1; cpu_we = $urandom_range(0, 1) == 1;
            cpu_addr = AW'($urandom); cpu_din = 8'($urandom);
         end
      end else if ($urandom_range(0, 49) == 0) begin
         cpu_req = 0;
      end
   endtask

   initial begin
      int n;

      // CPU read alone: ack at slot start, data two cycles later
      do_reset();
      cpu_req = 1; cpu_we = 0; cpu_addr = 25'h01234;
      dout_fix_en = 1'b1; dout_fix = 8'h5A;
      #1;
      check("rd_wait_before_ack", cpu_wait_n, 0);
      wait_cpu_ack(8, n);
      check("rd_ack_seen", cpu_ack, 1);
      check("rd_ack_latency", n, 2);
      check("rd_sd_addr", sd_addr, 25'h01234);
      check("rd_sd_oe", sd_oe, 1);
      cpu_req = 0;
      tick();
      check("rd_valid_early", cpu_valid, 0);
      tick();
      check("rd_valid", cpu_valid, 1);
      check("rd_dout", cpu_dout, 8'h5A);
      dout_fix_en = 1'b0;

      // Both requesters saturated: V,V,V,V,C repeating with no idle slot
      do_reset();
      vid_req = 1; vid_addr = 25'h00ABC;
      cpu_req = 1; cpu_we = 0; cpu_addr = 25'h00DEF;
      tick();
      for (int i = 0; i < 10; i++) begin
         tick();
         check("starve_grant", {vid_ack, cpu_ack}, (i % 5 == 4) ? 2'b01 : 2'b10);
         check("starve_busy_c0", sd_oe, 1);
         tick();
         check("starve_busy_c1", sd_oe, 1);
      end

      // Download stream: 16 writes, one every 4 cycles
      do_reset();
      dl_active = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 25'h00333;
      prev_we = 0; n_wr = 0; n_wait_hi = 0;
      q_a.delete(); q_d.delete();
      for (int i = 0; i < 16; i++) begin
         dl_wr = 1; dl_addr = AW'(i); dl_data = 8'($urandom);
         q_a.push_back(dl_addr); q_d.push_back(dl_data);
         tick_dl();
         dl_wr = 0;
         for (int k = 0; k < 3; k++) tick_dl();
      end
      for (int k = 0; k < 8; k++) tick_dl();
      check("dl_write_count", n_wr, 16);
      check("dl_queue_drained", q_a.size(), 0);
      check("dl_no_overflow", dl_overflow, 0);
      check("dl_wait_always_low", n_wait_hi, 0);

      // Back-to-back download strobes: second one is lost and flagged
      do_reset();
      dl_active = 1; prev_we = 0; n_wr = 0; n_wait_hi = 0;
      q_a.delete(); q_d.delete();
      dl_wr = 1; dl_addr = 25'h00100; dl_data = 8'h11;
      q_a.push_back(dl_addr); q_d.push_back(dl_data);
      tick_dl();
      dl_wr = 1; dl_addr = 25'h00200; dl_data = 8'h22;
      tick_dl();
      dl_wr = 0;
      check("ovf_set", dl_overflow, 1);
      for (int k = 0; k < 8; k++) tick_dl();
      check("ovf_only_first_written", n_wr, 1);
      check("ovf_sticky", dl_overflow, 1);
      RESET = 0;
      tick();
      check("ovf_cleared_by_reset", dl_overflow, 0);

      // Reset in second cycle of a CPU read slot
      do_reset();
      cpu_req = 1; cpu_we = 0; cpu_addr = 25'h0ABCD;
      wait_cpu_ack(8, n);
      check("rst_ack_seen", cpu_ack, 1);
      cpu_req = 0;
      tick();
      RESET = 0;
      tick();
      check("rst_cpu_valid", cpu_valid, 0);
      check("rst_cpu_ack", cpu_ack, 0);
      check("rst_vid_ack", vid_ack, 0);
      check("rst_vid_valid", vid_valid, 0);
      check("rst_sd_we", sd_we, 0);
      check("rst_sd_oe", sd_oe, 0);
      check("rst_sd_addr", sd_addr, 0);
      check("rst_sd_din", sd_din, 0);
      check("rst_vid_data", vid_data, 0);
      check("rst_cpu_dout", cpu_dout, 0);
      check("rst_wait_n", cpu_wait_n, 1);
      RESET = 1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("rst_no_late_valid", cpu_valid, 0);
      end

      // CPU write alongside a video request: video first, then the write
      do_reset();
      vid_req = 1; vid_addr = 25'h00777;
      cpu_req = 1; cpu_we = 1; cpu_addr = 25'h1FFFF; cpu_din = 8'hA5;
      tick();
      tick();
      check("wr_video_first", {vid_ack, cpu_ack}, 2'b10);
      vid_req = 0;
      wait_cpu_ack(6, n);
      check("wr_ack_seen", cpu_ack, 1);
      check("wr_sd_we_c0", sd_we, 1);
      check("wr_sd_oe_c0", sd_oe, 0);
      check("wr_sd_addr_c0", sd_addr, 25'h1FFFF);
      check("wr_sd_din_c0", sd_din, 8'hA5);
      cpu_req = 0;
      tick();
      check("wr_sd_we_c1", sd_we, 1);
      check("wr_sd_addr_c1", sd_addr, 25'h1FFFF);
      check("wr_sd_din_c1", sd_din, 8'hA5);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("wr_no_valid", cpu_valid, 0);
      end

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         rand_agents();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
